n_way_plru_cache: RTL and testbench
===================================

// Module: n_way_plru_cache
// PURPOSE
//  Parametrised N-way set-associative data cache: write-back, write-allocate, tree-PLRU replacement.
//  Generalises the two-way LRU cache in three ways: configurable way count, per-line dirty bits,
//  and a memory-side FSM that performs victim write-back and line refill.
//  Sits between the core load/store unit (valid/ready request, registered response) and the backing data memory.
// PARAMETERS
//  ADDR_SIZE    32  byte-address width
//  NUM_SETS     16  number of sets; power of 2, >=2
//  NUM_WAYS     4   associativity; power of 2, >=2
//  BLOCK_WORDS  4   32-bit words per line; power of 2, >=1
//  Derived: OFF=$clog2(BLOCK_WORDS)+2, SET=$clog2(NUM_SETS), TAG=ADDR_SIZE-SET-OFF
// PORTS
//  clk            in   1          clock, all state updates on rising edge
//  rst            in   1          asynchronous, active-high reset
//  req_valid      in   1          core request valid
//  req_ready      out  1          cache can accept a request
//  req_write      in   1          1=store, 0=load
//  req_addr       in   ADDR_SIZE  byte address; bits [1:0] ignored
//  req_wdata      in   32         store data
//  resp_valid     out  1          one-cycle pulse, response for accepted request
//  resp_rdata     out  32         load data (store: word after write)
//  resp_hit       out  1          qualifies resp_valid: 1=hit, 0=serviced via miss path
//  mem_valid      out  1          memory word transaction valid
//  mem_ready      in   1          memory completes transaction this cycle
//  mem_write      out  1          1=write-back beat, 0=refill beat
//  mem_addr       out  ADDR_SIZE  word-aligned beat address
//  mem_wdata      out  32         write-back data
//  mem_rdata      in   32         refill data, valid when mem_valid&mem_ready&!mem_write
// BEHAVIOUR
//  Reset: all valid, dirty and PLRU bits cleared; state=IDLE; req_ready=1; resp_valid=0; mem_valid=0;
//   mem_write=0; mem_addr=0; resp_rdata=0; resp_hit=0. Data/tag arrays are not reset.
//  Accept: req_valid&req_ready captures addr/write/wdata. req_ready=1 only in IDLE.
//  FSM states: IDLE -> COMPARE (on accept).
//   COMPARE, hit: load returns word; store updates word and sets dirty; PLRU is touched;
//     resp_valid=1, resp_hit=1 next cycle; return to IDLE. Hit latency is 2 cycles from accept.
//   COMPARE, miss: choose victim = lowest-index invalid way, otherwise the PLRU way.
//     Victim valid&dirty -> WRITEBACK; otherwise -> REFILL.
//   WRITEBACK: BLOCK_WORDS beats, addresses {victim_tag,set,beat,2'b0}, beat 0..N-1 ascending.
//     Beat counter advances only on mem_ready. Last beat -> REFILL.
//   REFILL: BLOCK_WORDS read beats, addresses {req_tag,set,beat,2'b0}; each mem_rdata is written into the victim.
//     Last beat: tag written, valid=1, dirty=0 -> RESPOND.
//   RESPOND: perform the original access as a hit (store sets dirty); touch PLRU;
//     resp_valid=1, resp_hit=0; return to IDLE.
//  mem_* outputs stay stable while mem_valid=1 and mem_ready=0. mem_valid=0 in IDLE/COMPARE/RESPOND.
//  Tree PLRU: NUM_WAYS-1 bits per set. Touch sets each node on the path to point away from the accessed way.
//   Victim follows node pointers from the root. A node bit of 0 means the victim is in the left (lower) half.
//  Fixed priority: only one request is outstanding at a time. No request is accepted during a miss.
//   A request presented in the same cycle as resp_valid is accepted (IDLE already reached).
//  Reset mid-miss: the FSM aborts and the line is not made valid. Memory must tolerate a dropped beat.
// TESTING (NUM_SETS=16, NUM_WAYS=4, BLOCK_WORDS=4)
//  1 Cold load 0x104: 4 refill beats 0x100..0x10C with data 0xA0..0xA3 -> resp_rdata=0xA1, resp_hit=0;
//    reload 0x104 -> resp_hit=1 two cycles after accept.
//  2 Store 0x100=0xDEAD (hit) -> dirty; load 0x100 -> 0xDEAD, no mem_valid asserted.
//  3 Fill set 0: loads 0x000, 0x100, 0x200, 0x300 (ways 0..3), then touch 0x100, 0x300;
//    miss 0x400 evicts way 0 (0x000): refill 0x400..0x40C only, no write beats.
//  4 Dirty eviction: store 0x000=0x55, touch 0x100..0x300, load 0x400 -> 4 write beats 0x000..0x00C
//    (first mem_wdata=0x55), then 4 reads 0x400..0x40C.
//  5 Backpressure: hold mem_ready=0 for 5 cycles per beat -> mem_addr/mem_wdata stable;
//    req_ready=0 throughout the miss; response is correct.
//  6 Assert rst during REFILL beat 2 -> all outputs return to reset values;
//    load of the same address misses again.

Source files
------------

// File: rtl/n_way_plru_cache.sv
// n_way_plru_cache
//   N-way set-associative data cache between a load/store unit and a word-wide
//   backing memory. Write-back, write-allocate, tree-PLRU replacement, one
//   request outstanding at a time.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req_*/o_req_ready  core request handshake (addr, write, wdata)
//   o_resp_*             one-cycle response pulse with load data and hit flag
//   o_mem_*/i_mem_*      memory beat interface: one 32-bit word per
//                        mem_valid & mem_ready, write-back or refill
//
// Line layout: address = {tag, set, word, 2'b00}. Data and tag arrays are
// not reset; only valid/dirty/PLRU state is.
module n_way_plru_cache #(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_resp_valid,
  output logic [31:0]          o_resp_rdata,
  output logic                 o_resp_hit,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 o_mem_write,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  input  logic [31:0]          i_mem_rdata
);

  localparam int OFF_W = $clog2(BLOCK_WORDS) + 2;
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_SIZE - SET_W - OFF_W;
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int BW_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_t;

  state_t                              r_state;
  logic [ADDR_SIZE-1:0]                r_addr;
  logic                                r_write;
  logic [31:0]                         r_wdata;
  logic [WAY_W-1:0]                    r_victim;
  logic [BW_W-1:0]                     r_beat;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]   r_valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]   r_dirty;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0]   r_plru;
  logic [TAG_W-1:0]                    r_tag  [NUM_SETS][NUM_WAYS];
  logic [31:0]                         r_data [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

  logic                                r_resp_valid;
  logic [31:0]                         r_resp_rdata;
  logic                                r_resp_hit;
  logic                                r_mem_valid;
  logic                                r_mem_write;
  logic [ADDR_SIZE-1:0]                r_mem_addr;
  logic [31:0]                         r_mem_wdata;

  // Byte-offset bits of the request address are don't-care.
  logic w_unused;
  assign w_unused = ^i_req_addr[1:0];

  logic [TAG_W-1:0] w_tag;
  logic [SET_W-1:0] w_set;
  logic [BW_W-1:0]  w_word;
  assign w_tag = r_addr[ADDR_SIZE-1 -: TAG_W];
  assign w_set = r_addr[OFF_W +: SET_W];

  generate
    if (BLOCK_WORDS > 1) begin : g_word
      assign w_word = r_addr[OFF_W-1:2];
    end else begin : g_word1
      assign w_word = '0;
    end
  endgenerate

  // Tree PLRU, heap-ordered: node n has children 2n+1 (lower half) and 2n+2.
  // A node bit of 0 points the victim search at the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
    logic [WAY_W:0] n;
    n = '0;
    for (int l = 0; l < WAY_W; l++)
      n = (n << 1) + (WAY_W+1)'(1) + {{WAY_W{1'b0}}, t[n[WAY_W-1:0]]};
    n = n - (WAY_W+1)'(NUM_WAYS - 1);
    return n[WAY_W-1:0];
  endfunction

  // Walk the path of the accessed way and point every node away from it.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t,
                                                     input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] r;
    logic [WAY_W:0]      n;
    logic [WAY_W-1:0]    ws;
    logic                dir;
    r  = t;
    n  = '0;
    ws = way;
    for (int l = 0; l < WAY_W; l++) begin
      dir = ws[WAY_W-1];
      ws  = ws << 1;
      r[n[WAY_W-1:0]] = ~dir;
      n = (n << 1) + (WAY_W+1)'(1) + {{WAY_W{1'b0}}, dir};
    end
    return r;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                     input logic [SET_W-1:0] s,
                                                     input logic [BW_W-1:0]  b);
    logic [ADDR_SIZE-1:0] a;
    a = {t, s, {OFF_W{1'b0}}};
    a = a | (ADDR_SIZE'(b) << 2);
    return a;
  endfunction

  // Lookup
  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_has_inv;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    w_victim = w_has_inv ? w_inv_way : plru_victim(r_plru[w_set]);
  end

  logic [WAY_W-1:0] w_rd_way;
  logic [31:0]      w_rd_word;
  logic             w_last;
  logic [BW_W-1:0]  w_beat_nxt;
  assign w_rd_way   = (r_state == S_COMPARE) ? w_hit_way : r_victim;
  assign w_rd_word  = r_data[w_set][w_rd_way][w_word];
  assign w_last     = (r_beat == BW_W'(BLOCK_WORDS - 1));
  assign w_beat_nxt = r_beat + BW_W'(1);

  // Array write port: store hit, refill beat, or the store replayed after a miss.
  logic             w_dwe;
  logic [WAY_W-1:0] w_dway;
  logic [BW_W-1:0]  w_dword;
  logic [31:0]      w_dwdata;
  logic             w_twe;

  always_comb begin
    w_dwe    = 1'b0;
    w_dway   = r_victim;
    w_dword  = w_word;
    w_dwdata = r_wdata;
    w_twe    = 1'b0;
    case (r_state)
      S_COMPARE: begin
        w_dwe  = w_hit && r_write;
        w_dway = w_hit_way;
      end
      S_REFILL: begin
        w_dwe    = i_mem_ready;
        w_dword  = r_beat;
        w_dwdata = i_mem_rdata;
        w_twe    = i_mem_ready && w_last;
      end
      S_RESPOND: w_dwe = r_write;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_dwe) r_data[w_set][w_dway][w_dword] <= w_dwdata;
    if (w_twe) r_tag[w_set][r_victim]         <= w_tag;
  end

  // Control FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_victim     <= '0;
      r_beat       <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_plru       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_addr  <= i_req_addr;
            r_write <= i_req_write;
            r_wdata <= i_req_wdata;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_plru[w_set] <= plru_touch(r_plru[w_set], w_hit_way);
            if (r_write) r_dirty[w_set][w_hit_way] <= 1'b1;
            r_resp_rdata <= r_write ? r_wdata : w_rd_word;
            r_resp_hit   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_victim    <= w_victim;
            r_beat      <= '0;
            r_mem_valid <= 1'b1;
            if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= beat_addr(r_tag[w_set][w_victim], w_set, '0);
              r_mem_wdata <= r_data[w_set][w_victim][0];
              r_state     <= S_WRITEBACK;
            end else begin
              r_mem_write <= 1'b0;
              r_mem_addr  <= beat_addr(w_tag, w_set, '0);
              r_state     <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (i_mem_ready) begin
            if (w_last) begin
              r_beat      <= '0;
              r_mem_write <= 1'b0;
              r_mem_addr  <= beat_addr(w_tag, w_set, '0);
              r_state     <= S_REFILL;
            end else begin
              r_beat      <= w_beat_nxt;
              r_mem_addr  <= beat_addr(r_tag[w_set][r_victim], w_set, w_beat_nxt);
              r_mem_wdata <= r_data[w_set][r_victim][w_beat_nxt];
            end
          end
        end
        S_REFILL: begin
          if (i_mem_ready) begin
            if (w_last) begin
              r_mem_valid               <= 1'b0;
              r_valid[w_set][r_victim]  <= 1'b1;
              r_dirty[w_set][r_victim]  <= 1'b0;
              r_state                   <= S_RESPOND;
            end else begin
              r_beat     <= w_beat_nxt;
              r_mem_addr <= beat_addr(w_tag, w_set, w_beat_nxt);
            end
          end
        end
        S_RESPOND: begin
          r_plru[w_set] <= plru_touch(r_plru[w_set], r_victim);
          if (r_write) r_dirty[w_set][r_victim] <= 1'b1;
          r_resp_rdata <= r_write ? r_wdata : w_rd_word;
          r_resp_hit   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_hit   = r_resp_hit;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_write  = r_mem_write;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_n_way_plru_cache.sv
module tb_n_way_plru_cache;
  localparam int NS = 16, NW = 4, BW = 4, LV = 2;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_write = 1'b0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0;
  logic        o_req_ready, o_resp_valid, o_resp_hit;
  logic [31:0] o_resp_rdata;
  logic        o_mem_valid, o_mem_write;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;

  n_way_plru_cache #(.ADDR_SIZE(32), .NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_hit(o_resp_hit),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  typedef struct { logic [31:0] rd; bit hit; int acc; } exp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } beat_t;
  exp_t  exp_q[$];
  beat_t beat_q[$];

  // Memory: phys is what the DUT actually sees, ref is the model's view.
  logic [31:0] phys_mem[logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] mdef(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction
  function automatic logic [31:0] phys_rd(logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : mdef(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mdef(a);
  endfunction

  // Reference cache: lines per set/way; PLRU tree stored as node bits by (level, path prefix).
  bit          mv[NS][NW], md[NS][NW];
  int unsigned mt[NS][NW];
  logic [31:0] mw[NS][NW][BW];
  bit          pb[NS][LV][NW];

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 0; md[s][w] = 0; pb[s][0][w] = 0; pb[s][1][w] = 0;
      end
  endtask

  task automatic touch(int s, int way);
    for (int l = 0; l < LV; l++)
      pb[s][l][way >> (LV - l)] = !((way >> (LV - 1 - l)) & 1);
  endtask

  function automatic int plru_way(int s);
    int p = 0;
    for (int l = 0; l < LV; l++) p = p * 2 + int'(pb[s][l][p]);
    return p;
  endfunction

  task automatic model_access(bit wr, logic [31:0] a, logic [31:0] d, int acc);
    int s, wd, way;
    int unsigned tg;
    exp_t e;
    logic [31:0] ba;
    s = int'((a >> 4) & 32'hF); wd = int'((a >> 2) & 32'h3); tg = a >> 8;
    way = -1;
    for (int w = 0; w < NW; w++) if (mv[s][w] && mt[s][w] == tg) way = w;
    e.hit = (way >= 0);
    if (way < 0) begin
      for (int w = NW - 1; w >= 0; w--) if (!mv[s][w]) way = w;
      if (way < 0) way = plru_way(s);
      if (mv[s][way] && md[s][way])
        for (int k = 0; k < BW; k++) begin
          ba = (mt[s][way] << 8) | (s << 4) | (k << 2);
          beat_q.push_back('{1'b1, ba, mw[s][way][k]});
          ref_mem[ba] = mw[s][way][k];
        end
      for (int k = 0; k < BW; k++) begin
        ba = (tg << 8) | (s << 4) | (k << 2);
        beat_q.push_back('{1'b0, ba, 32'h0});
        mw[s][way][k] = ref_rd(ba);
      end
      mv[s][way] = 1; md[s][way] = 0; mt[s][way] = tg;
    end
    if (wr) begin mw[s][way][wd] = d; md[s][way] = 1; end
    e.rd = mw[s][way][wd];
    e.acc = acc;
    touch(s, way);
    exp_q.push_back(e);
  endtask

  // Response monitor
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mem_valid) chk("req_ready during miss", {31'b0, o_req_ready}, 32'h0);
      if (o_resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected resp_valid", 32'h1, 32'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", o_resp_rdata, e.rd);
          chk("resp_hit", {31'b0, o_resp_hit}, {31'b0, e.hit});
          if (e.hit) chk("hit latency", cyc - e.acc, 32'd2);
        end
      end
    end
  end

  // Memory responder with configurable per-beat stall
  int bp_min = 0, bp_max = 0, beats_done = 0;
  bit busy = 0;
  int dly = 0;
  logic        cap_wr;
  logic [31:0] cap_addr, cap_wd;
  always @(negedge i_clk) begin
    if (i_rst) begin
      busy = 0; i_mem_ready = 0;
    end else begin
      if (i_mem_ready) begin
        beat_t b;
        i_mem_ready = 0; busy = 0; beats_done++;
        if (beat_q.size() == 0) chk("unexpected mem beat", cap_addr, 32'hFFFF_FFFF);
        else begin
          b = beat_q.pop_front();
          chk("mem_write", {31'b0, cap_wr}, {31'b0, b.wr});
          chk("mem_addr", cap_addr, b.addr);
          if (b.wr) chk("mem_wdata", cap_wd, b.data);
        end
        if (cap_wr) phys_mem[cap_addr] = cap_wd;
      end
      if (o_mem_valid) begin
        if (!busy) begin
          busy = 1; cap_wr = o_mem_write; cap_addr = o_mem_addr; cap_wd = o_mem_wdata;
          dly = $urandom_range(bp_max, bp_min);
        end else begin
          chk("stall mem_addr stable", o_mem_addr, cap_addr);
          chk("stall mem_write stable", {31'b0, o_mem_write}, {31'b0, cap_wr});
          if (cap_wr) chk("stall mem_wdata stable", o_mem_wdata, cap_wd);
        end
        if (dly == 0) begin
          i_mem_ready = 1; i_mem_rdata = cap_wr ? 32'h0 : phys_rd(cap_addr);
        end else dly--;
      end
    end
  end

  task automatic issue(bit wr, logic [31:0] a, logic [31:0] d);
    int t = 0;
    i_req_valid = 1; i_req_write = wr; i_req_addr = a; i_req_wdata = d;
    while (!o_req_ready && t < 500) begin @(negedge i_clk); t++; end
    if (t >= 500) chk("req_ready wait", {31'b0, o_req_ready}, 32'h1);
    model_access(wr, a, d, cyc);
    @(negedge i_clk);
    i_req_valid = 0;
  endtask

  task automatic do_reset(bit check);
    i_rst = 1; i_req_valid = 0;
    exp_q.delete(); beat_q.delete(); model_reset();
    repeat (2) @(negedge i_clk);
    if (check) begin
      chk("rst req_ready", {31'b0, o_req_ready}, 32'h1);
      chk("rst resp_valid", {31'b0, o_resp_valid}, 32'h0);
      chk("rst resp_hit", {31'b0, o_resp_hit}, 32'h0);
      chk("rst resp_rdata", o_resp_rdata, 32'h0);
      chk("rst mem_valid", {31'b0, o_mem_valid}, 32'h0);
      chk("rst mem_write", {31'b0, o_mem_write}, 32'h0);
      chk("rst mem_addr", o_mem_addr, 32'h0);
    end
    i_rst = 0;
    @(negedge i_clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_mem_valid) && t < 300) begin @(negedge i_clk); t++; end
    chk("responses drained", exp_q.size(), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      phys_mem[32'h100 + 4*k] = 32'hA0 + k;
      ref_mem [32'h100 + 4*k] = 32'hA0 + k;
    end
    @(negedge i_clk);
    do_reset(1);

    // Cold load, then reload hit; store hit and readback
    issue(0, 32'h104, 0);
    issue(0, 32'h104, 0);
    issue(1, 32'h100, 32'hDEAD);
    issue(0, 32'h100, 0);
    drain();

    // Fill set 0, touch ways 1 and 3, clean eviction of way 0
    do_reset(0);
    for (int k = 0; k < 4; k++) issue(0, 32'h100 * k, 0);
    issue(0, 32'h100, 0);
    issue(0, 32'h300, 0);
    issue(0, 32'h400, 0);
    drain();

    // Dirty eviction of way 0
    do_reset(0);
    for (int k = 0; k < 4; k++) issue(0, 32'h100 * k, 0);
    issue(1, 32'h000, 32'h55);
    issue(0, 32'h100, 0);
    issue(0, 32'h200, 0);
    issue(0, 32'h300, 0);
    issue(0, 32'h400, 0);
    drain();

    // Heavy backpressure with dirty evictions
    bp_min = 5; bp_max = 5;
    issue(1, 32'h504, 32'h1234_5678);
    issue(1, 32'h608, 32'h0BAD_F00D);
    for (int k = 7; k < 10; k++) issue(0, 32'h100 * k, 0);
    issue(0, 32'h504, 0);
    drain();

    // Reset while refill beat 2 is stalled, then the same load misses again
    begin
      int t = 0;
      beats_done = 0;
      issue(0, 32'hA40, 0);
      while (beats_done < 2 && t < 200) begin @(negedge i_clk); t++; end
      chk("refill beats before reset", beats_done, 32'd2);
      do_reset(1);
      issue(0, 32'hA40, 0);
      drain();
    end

    // Randomised traffic over a small tag/set space to force conflicts
    bp_min = 0; bp_max = 3;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(5, 0) << 8) | ($urandom_range(3, 0) << 4) | ($urandom_range(3, 0) << 2);
      issue($urandom_range(9, 0) < 4, a, $urandom);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(2, 1)) @(negedge i_clk);
    end
    drain();
    chk("no leftover beats", beat_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
